// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - command encodings, FSM states and TMS sequence lengths for the JTAG host shifter
package jtag_host_pkg;

    localparam logic [1:0] OP_DR   = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_RST_SEQ = 3'd0;
    localparam state_t ST_IDLE    = 3'd1;
    localparam state_t ST_PRE     = 3'd2;
    localparam state_t ST_SHIFT   = 3'd3;
    localparam state_t ST_POST    = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    localparam int PRE_DR_TCKS  = 3;
    localparam int PRE_IR_TCKS  = 4;
    localparam int POST_TCKS    = 2;
    localparam int RST_SEQ_TCKS = 6;

    function automatic int pre_tcks(input logic [1:0] op);
        return (op == OP_IR) ? PRE_IR_TCKS : PRE_DR_TCKS;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider: low half then high half, TCK_HALF clk each, with fall/rise strobes
module jtag_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int CNT_W = (TCK_HALF > 1) ? $clog2(2 * TCK_HALF) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tck;

    // Strobes mark the clk edge on which tck itself changes level.
    assign rise_stb = en && (r_cnt == CNT_W'(TCK_HALF - 1));
    assign fall_stb = en && (r_cnt == CNT_W'(2 * TCK_HALF - 1));
    assign tck      = r_tck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (en) begin
            if (fall_stb) begin
                r_cnt <= '0;
                r_tck <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (rise_stb) r_tck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_host_shifter.sv
// rtl/jtag_host_shifter.sv - JTAG host initiator; JTAG_LOOPBACK_EN captures delayed tdi instead of tdo
module jtag_host_shifter
    import jtag_host_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 5,
    parameter int TCK_HALF = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);
    state_t            r_state;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_len;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_rsp;

    state_t w_next;
    logic   w_en, w_fall, w_rise, w_last, w_tms, w_tdi, w_cap;

    assign w_en = (r_state != ST_IDLE) && (r_state != ST_DONE);

    jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (w_en),
        .tck      (tck),
        .fall_stb (w_fall),
        .rise_stb (w_rise)
    );

`ifdef JTAG_LOOPBACK_EN
    logic r_loop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_loop <= 1'b0;
        else if (w_rise) r_loop <= w_tdi;
    end
    assign w_cap = r_loop;
`else
    assign w_cap = tdo;
`endif

    // Preamble always ends with two tms=0 TCKs (Capture, Shift); the leading ones select DR or IR.
    always_comb begin
        w_last = 1'b0;
        w_next = ST_IDLE;
        w_tms  = 1'b0;
        w_tdi  = 1'b0;
        case (r_state)
            ST_RST_SEQ: begin
                w_last = (r_idx == LEN_W'(RST_SEQ_TCKS - 1));
                w_next = (r_op == OP_RST) ? ST_DONE : ST_IDLE;
                w_tms  = !w_last;
            end
            ST_PRE: begin
                w_last = (r_idx == LEN_W'(pre_tcks(r_op) - 1));
                w_next = ST_SHIFT;
                w_tms  = (r_idx < LEN_W'(pre_tcks(r_op) - 2));
            end
            ST_SHIFT: begin
                w_last = (r_idx == r_len - LEN_W'(1));
                w_next = (r_op == OP_IDLE) ? ST_DONE : ST_POST;
                w_tms  = (r_op != OP_IDLE) && w_last;
                w_tdi  = (r_op != OP_IDLE) && r_data[r_idx];
            end
            ST_POST: begin
                w_last = (r_idx == LEN_W'(POST_TCKS - 1));
                w_next = ST_DONE;
                w_tms  = (r_idx == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST_SEQ;
            r_idx   <= '0;
            r_len   <= '0;
            r_op    <= OP_DR;
            r_data  <= '0;
            r_acc   <= '0;
            r_rsp   <= '0;
        end else begin
            if (w_rise && (r_state == ST_SHIFT) && (r_op != OP_IDLE))
                r_acc[r_idx] <= w_cap;
            if (r_state == ST_IDLE) begin
                if (cmd_valid) begin
                    r_op   <= cmd_op;
                    r_len  <= cmd_len;
                    r_data <= cmd_data;
                    r_acc  <= '0;
                    r_idx  <= '0;
                    r_state <= (cmd_op == OP_RST)  ? ST_RST_SEQ :
                               (cmd_op == OP_IDLE) ? ST_SHIFT   : ST_PRE;
                end
            end else if (r_state == ST_DONE) begin
                r_state <= ST_IDLE;
            end else if (w_fall) begin
                if (w_last) begin
                    r_idx   <= '0;
                    r_state <= w_next;
                    if (w_next == ST_DONE) r_rsp <= r_acc;
                end else begin
                    r_idx <= r_idx + LEN_W'(1);
                end
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_data  = r_rsp;
    assign tms       = w_tms;
    assign tdi       = w_tdi;

endmodule
